// File: rtl/vga_video_receiver.sv
// vga_video_receiver: captures active VGA pixels into framed packets
// ({R,G,B} beats with sop/eop). A show-ahead FIFO buffers the beats, and
// its last entry is kept for a terminating EOP when a frame is truncated.
module vga_video_receiver #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic        VS_POL     = 1'b0
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        vid_vs,
  input  logic        vid_blank,
  input  logic [7:0]  vid_r,
  input  logic [7:0]  vid_g,
  input  logic [7:0]  vid_b,
  input  logic        enable,
  output logic [23:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_sop,
  output logic        src_eop,
  output logic [11:0] frame_width,
  output logic [11:0] frame_height,
  output logic [15:0] frame_count,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 24;
  localparam int unsigned SW = 12;
  localparam int unsigned FW = 16;
  localparam logic [SW-1:0] SIZE_MAX = '1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] RESV_C   = CW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [PW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FS, S_CAPTURE, S_DROP} state_t;

  state_t state_q, state_d;

  // registered video inputs and their one-cycle-delayed copies
  logic          vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic          blank_q, blank_d, blank_prev_q, blank_prev_d;
  logic [PW-1:0] pix_q, pix_d;

  // one-entry hold register
  logic          hold_valid_q, hold_valid_d;
  logic [PW-1:0] hold_data_q, hold_data_d;
  logic          hold_sop_q, hold_sop_d;
  logic          first_q, first_d;

  // frame measurement
  logic [SW-1:0] w_q, w_d, h_q, h_d, h_next_c;
  logic [SW-1:0] fw_q, fw_d, fh_q, fh_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          ovf_q, ovf_d;

  // output FIFO
  beat_t         mem_q [FIFO_DEPTH];
  beat_t         mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // control strobes from the FSM output process
  logic  fs_c, rise_c, pop_c, can_push_c, reserve_c;
  logic  push_c, load_hold_c, clear_hold_c, restart_c, done_c, ovf_set_c, count_en_c;
  beat_t push_beat_c;

  // event detection on the registered inputs
  assign fs_c       = (vs_q == VS_POL) && (vs_prev_q != VS_POL);
  assign rise_c     = blank_q && !blank_prev_q;
  assign src_valid  = (cnt_q != '0);
  assign pop_c      = src_valid && src_ready;
  assign can_push_c = (cnt_q != DEPTH_C) || pop_c;
  assign reserve_c  = (cnt_q >= RESV_C);

  // show-ahead head, forced to zero while empty
  assign src_data     = src_valid ? mem_q[rd_q].data : '0;
  assign src_sop      = src_valid ? mem_q[rd_q].sop  : 1'b0;
  assign src_eop      = src_valid ? mem_q[rd_q].eop  : 1'b0;
  assign frame_width  = fw_q;
  assign frame_height = fh_q;
  assign frame_count  = fc_q;
  assign overflow     = ovf_q;

  // FSM state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable) state_d = S_WAIT_FS;
      S_WAIT_FS: if (fs_c) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (fs_c)                                      state_d = enable ? S_CAPTURE : S_IDLE;
        else if (blank_q && hold_valid_q && reserve_c) state_d = S_DROP;
      end
      S_DROP:    if (fs_c) state_d = enable ? S_CAPTURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: push requests and datapath strobes
  always_comb begin
    push_c       = 1'b0;
    push_beat_c  = '0;
    load_hold_c  = 1'b0;
    clear_hold_c = 1'b0;
    restart_c    = 1'b0;
    done_c       = 1'b0;
    ovf_set_c    = 1'b0;
    count_en_c   = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        if (fs_c) begin
          restart_c    = 1'b1;
          clear_hold_c = 1'b1;
          if (hold_valid_q) begin
            if (can_push_c) begin
              push_c      = 1'b1;
              push_beat_c = '{data: hold_data_q, sop: hold_sop_q, eop: 1'b1};
              done_c      = 1'b1;
            end else begin
              ovf_set_c = 1'b1;
            end
          end
        end else begin
          count_en_c = 1'b1;
          if (blank_q) begin
            if (!hold_valid_q) begin
              load_hold_c = 1'b1;
            end else if (!reserve_c) begin
              push_c      = 1'b1;
              push_beat_c = '{data: hold_data_q, sop: hold_sop_q, eop: 1'b0};
              load_hold_c = 1'b1;
            end else begin
              // truncate: close the packet in the reserved slot
              ovf_set_c    = 1'b1;
              clear_hold_c = 1'b1;
              if (can_push_c) begin
                push_c      = 1'b1;
                push_beat_c = '{data: hold_data_q, sop: hold_sop_q, eop: 1'b1};
              end
            end
          end
        end
      end
      S_WAIT_FS, S_DROP: begin
        if (fs_c) begin
          restart_c    = 1'b1;
          clear_hold_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // datapath next-state: input regs, hold, measurement, FIFO
  always_comb begin
    vs_d         = vid_vs;
    vs_prev_d    = vs_q;
    blank_d      = vid_blank;
    blank_prev_d = blank_q;
    pix_d        = {vid_r, vid_g, vid_b};
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_sop_d   = hold_sop_q;
    first_d      = first_q;
    w_d          = w_q;
    h_d          = h_q;
    h_next_c     = h_q;
    fw_d         = fw_q;
    fh_d         = fh_q;
    fc_d         = fc_q;
    ovf_d        = ovf_q;
    mem_d        = mem_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q + CW'(push_c) - CW'(pop_c);

    if (clear_hold_c) hold_valid_d = 1'b0;
    if (load_hold_c) begin
      hold_valid_d = 1'b1;
      hold_data_d  = pix_q;
      hold_sop_d   = first_q;
      first_d      = 1'b0;
    end

    // width counts only the first active line; height counts line starts
    if (count_en_c) begin
      if (rise_c && (h_q != SIZE_MAX)) h_next_c = h_q + SW'(1);
      h_d = h_next_c;
      if (blank_q && (h_next_c == SW'(1)) && (w_q != SIZE_MAX)) w_d = w_q + SW'(1);
    end
    if (done_c) begin
      fw_d = w_q;
      fh_d = h_q;
      fc_d = fc_q + FW'(1);
    end
    if (restart_c) begin
      first_d = 1'b1;
      w_d     = '0;
      h_d     = '0;
    end
    if (ovf_set_c) ovf_d = 1'b1;

    if (push_c) begin
      mem_d[wr_q] = push_beat_c;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_c) rd_d = rd_q + AW'(1);
  end

  // datapath registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      blank_q      <= 1'b0;
      blank_prev_q <= 1'b0;
      pix_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_sop_q   <= 1'b0;
      first_q      <= 1'b0;
      w_q          <= '0;
      h_q          <= '0;
      fw_q         <= '0;
      fh_q         <= '0;
      fc_q         <= '0;
      ovf_q        <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      blank_q      <= blank_d;
      blank_prev_q <= blank_prev_d;
      pix_q        <= pix_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_sop_q   <= hold_sop_d;
      first_q      <= first_d;
      w_q          <= w_d;
      h_q          <= h_d;
      fw_q         <= fw_d;
      fh_q         <= fh_d;
      fc_q         <= fc_d;
      ovf_q        <= ovf_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_vga_video_receiver.sv
// Bench for vga_video_receiver: frames are generated as pixel lists, the
// expected beat stream is queued per frame and checked at the sink.
module tb_vga_video_receiver;

  localparam int unsigned DEPTH  = 8;
  localparam logic        VS_POL = 1'b0;
  localparam int          HB     = 10;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        vid_vs, vid_blank, enable, src_ready;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic [23:0] src_data;
  logic        src_valid, src_sop, src_eop, overflow;
  logic [11:0] frame_width, frame_height;
  logic [15:0] frame_count;

  typedef struct {
    logic [23:0] d;
    logic        s;
    logic        e;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    mode  = 1;   // 0 stall, 1 ready, 2 random in active, 3 toggle
  int    exp_fc = 0, exp_fw = 0, exp_fh = 0;
  logic  exp_ovf = 1'b0;

  vga_video_receiver #(.FIFO_DEPTH(DEPTH), .VS_POL(VS_POL)) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .vid_vs       (vid_vs),
    .vid_blank    (vid_blank),
    .vid_r        (vid_r),
    .vid_g        (vid_g),
    .vid_b        (vid_b),
    .enable       (enable),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .frame_count  (frame_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock of video input; inputs change #1 after the rising edge
  task automatic cyc(input logic vs, input logic blank, input logic [23:0] pix);
    vid_vs    = vs;
    vid_blank = blank;
    {vid_r, vid_g, vid_b} = pix;
    case (mode)
      0:       src_ready = 1'b0;
      1:       src_ready = 1'b1;
      2:       src_ready = blank ? 1'($urandom_range(0, 1)) : 1'b1;
      default: src_ready = ~src_ready;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic vsync();
    repeat (2) cyc(VS_POL, 1'b0, 24'h0);
    repeat (3) cyc(~VS_POL, 1'b0, 24'h0);
  endtask

  // drives w x h active pixels; the first 'keep' pixels are expected as a packet
  task automatic frame(input int w, input int h, input bit seq, input int unsigned base,
                       input int keep, input int en_line);
    logic [23:0] px[$];
    beat_t       b;
    for (int i = 0; i < w * h; i++)
      px.push_back(seq ? 24'(base + 32'(i)) : 24'($urandom));
    for (int i = 0; i < keep; i++) begin
      b.d = px[i];
      b.s = (i == 0);
      b.e = (i == keep - 1);
      exp_q.push_back(b);
    end
    for (int l = 0; l < h; l++) begin
      if (l == en_line) enable = 1'b1;
      for (int x = 0; x < w; x++) cyc(~VS_POL, 1'b1, px[l * w + x]);
      repeat (HB) cyc(~VS_POL, 1'b0, 24'h0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_valid !== 1'b0) && n < 300) begin
      cyc(~VS_POL, 1'b0, 24'h0);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", src_valid, 1'b0);
  endtask

  task automatic check_sizes(input string tag);
    chk({tag, "_width"},  frame_width,  12'(exp_fw));
    chk({tag, "_height"}, frame_height, 12'(exp_fh));
    chk({tag, "_count"},  frame_count,  16'(exp_fc));
    chk({tag, "_ovf"},    overflow,     exp_ovf);
  endtask

  // sink monitor: head must match the model whenever valid, pop on handshake
  always @(negedge clk) begin
    if (src_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", src_data, 24'h0);
      end else begin
        chk("beat_data", src_data, exp_q[0].d);
        chk("beat_sop",  src_sop,  exp_q[0].s);
        chk("beat_eop",  src_eop,  exp_q[0].e);
        if (src_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h;
    reset_reset = 1'b1;
    enable      = 1'b0;
    src_ready   = 1'b1;
    vid_vs      = ~VS_POL;
    vid_blank   = 1'b0;
    {vid_r, vid_g, vid_b} = 24'h0;
    @(posedge clk);
    #1;
    repeat (2) cyc(~VS_POL, 1'b0, 24'h0);
    chk("rst_valid", src_valid, 1'b0);
    chk("rst_data",  src_data,  24'h0);
    chk("rst_sop",   src_sop,   1'b0);
    chk("rst_eop",   src_eop,   1'b0);
    check_sizes("rst");
    reset_reset = 1'b0;

    // directed 8x4 counting frame
    enable = 1'b1;
    mode   = 1;
    repeat (3) cyc(~VS_POL, 1'b0, 24'h0);
    vsync();
    frame(8, 4, 1'b1, 0, 32, -1);
    vsync();
    drain();
    exp_fw = 8; exp_fh = 4; exp_fc = 1;
    check_sizes("basic");

    // random frames with random stalls during active video
    mode = 2;
    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      frame(w, h, 1'b0, 0, w * h, -1);
      vsync();
      drain();
      exp_fw = w; exp_fh = h; exp_fc++;
      check_sizes("rand");
    end

    // frame with no active pixels
    mode = 1;
    repeat (30) cyc(~VS_POL, 1'b0, 24'h0);
    vsync();
    drain();
    check_sizes("empty");

    // sink stalled for a whole frame: truncation into the reserved slot
    mode = 0;
    frame(8, 4, 1'b1, 0, DEPTH, -1);
    vsync();
    exp_ovf = 1'b1;
    check_sizes("ovf");
    mode = 1;
    drain();
    check_sizes("ovf_drain");

    // enable dropped, then raised mid-frame
    enable = 1'b0;
    vsync();
    frame(8, 2, 1'b0, 0, 0, 1);
    vsync();
    drain();
    check_sizes("en_skip");
    frame(5, 3, 1'b0, 0, 15, -1);
    vsync();
    drain();
    exp_fw = 5; exp_fh = 3; exp_fc++;
    check_sizes("en_cap");

    // ready toggling every cycle
    mode = 3;
    frame(4, 2, 1'b1, 100, 8, -1);
    vsync();
    drain();
    exp_fw = 4; exp_fh = 2; exp_fc++;
    check_sizes("toggle");

    // reset pulse with three beats buffered
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      beat_t b;
      b.d = 24'(200 + i);
      b.s = (i == 0);
      b.e = 1'b0;
      exp_q.push_back(b);
    end
    for (int i = 0; i < 4; i++) cyc(~VS_POL, 1'b1, 24'(200 + i));
    repeat (3) cyc(~VS_POL, 1'b0, 24'h0);
    reset_reset = 1'b1;
    cyc(~VS_POL, 1'b0, 24'h0);
    reset_reset = 1'b0;
    exp_q.delete();
    exp_fc = 0; exp_fw = 0; exp_fh = 0; exp_ovf = 1'b0;
    chk("rst2_valid", src_valid, 1'b0);
    chk("rst2_data",  src_data,  24'h0);
    chk("rst2_sop",   src_sop,   1'b0);
    chk("rst2_eop",   src_eop,   1'b0);
    check_sizes("rst2");
    mode = 1;
    repeat (3) cyc(~VS_POL, 1'b0, 24'h0);
    vsync();
    frame(6, 3, 1'b0, 0, 18, -1);
    vsync();
    drain();
    exp_fw = 6; exp_fh = 3; exp_fc = 1;
    check_sizes("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_video_receiver.md
VGA_VIDEO_RECEIVER -- requirements
Module: vga_video_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output buffer entries; power of two, at least 4.
REQ-002 Parameter VS_POL, default 0, asserted level of vid_vs.
REQ-003 clk_clk  in  1  single clock; all inputs are synchronous to it.
REQ-004 reset_reset  in  1  synchronous, active-high reset.
REQ-005 vid_vs  in  1  vertical sync.
REQ-006 vid_blank  in  1  1 = active pixel, 0 = blanking.
REQ-007 vid_r / vid_g / vid_b  in  8 each  pixel colour.
REQ-008 enable  in  1  capture enable; sampled only at frame start.
REQ-009 src_data  out  24  pixel {R,G,B}, R in [23:16].
REQ-010 src_valid  out  1  beat valid.
REQ-011 src_ready  in  1  sink accepts beat.
REQ-012 src_sop / src_eop  out  1 each  first / last beat of a frame packet.
REQ-013 frame_width / frame_height  out  12 each  last completed frame's active size.
REQ-014 frame_count  out  16  completed frames, wraps at 65535 -> 0.
REQ-015 overflow  out  1  sticky; set when a frame was truncated.

Function
REQ-016 All video inputs SHALL be registered once; all detection SHALL use the registered copies.
REQ-017 Frame-start event (FS) SHALL be the cycle registered vid_vs changes to VS_POL.
REQ-018 States SHALL be IDLE, WAIT_FS, CAPTURE and DROP.
REQ-019 IDLE -> WAIT_FS when enable=1; WAIT_FS -> CAPTURE on FS.
REQ-020 In CAPTURE, each active pixel SHALL load a one-entry hold register; any pixel already held SHALL be pushed to the FIFO first, with sop=1 if it is the frame's first pixel.
REQ-021 On FS in CAPTURE: push the held pixel with eop=1, latch width/height, increment frame_count, clear hold; then CAPTURE if enable=1, else IDLE.
REQ-022 A frame with zero active pixels SHALL push nothing and change no counters or sizes.
REQ-023 Width SHALL be the active-pixel count of the first active line of the frame; height SHALL be the count of 0->1 vid_blank transitions; both saturate at 4095.
REQ-024 Normal pushes are allowed only while FIFO occupancy < FIFO_DEPTH-1; the last entry is reserved for a terminating EOP.
REQ-025 Normal push needed with occupancy = FIFO_DEPTH-1: push the held pixel with eop=1 into the reserved slot, set overflow, discard the incoming pixel, enter DROP.
REQ-026 DROP SHALL discard all pixels until FS, then behave as REQ-021 without counter/size update; the truncated frame is not counted.
REQ-027 FIFO SHALL be show-ahead: src_valid = not empty; src_data/src_sop/src_eop come from the head; pop when src_valid and src_ready.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged, including at full.
REQ-029 Latency: pixel on inputs at cycle N, followed by an active pixel at N+1, FIFO empty -> src_valid at cycle N+3.
REQ-030 src_data/src_sop/src_eop SHALL hold stable while src_valid=1 and src_ready=0.
REQ-031 overflow SHALL clear only on reset.

Reset
REQ-032 Reset SHALL set state IDLE and clear FIFO, hold register and input registers; src_valid, src_sop, src_eop, src_data, frame_width, frame_height, frame_count and overflow SHALL be 0 on the following cycle.
REQ-033 Reset mid-frame SHALL abandon the packet with no EOP; capture resumes at the first FS after enable=1.

Verification
REQ-034 enable=1, ready=1, 8x4 frame of pixel values 0..31, then FS -> 32 beats in order, sop on value 0, eop on value 31; width=8, height=4, frame_count=1.
REQ-035 FIFO_DEPTH=8, ready=0, 8x4 frame -> 8 buffered beats (values 0..7, eop on 7), overflow=1; after FS frame_count=0; releasing ready drains exactly 8 beats.
REQ-036 enable=0 during frame, raised mid-frame -> no beats until the next FS; the following full frame is captured completely.
REQ-037 Frame with vid_blank held 0 between two FS events -> no beats, frame_count and sizes unchanged.
REQ-038 reset_reset pulsed for 1 cycle mid-frame with 3 beats buffered -> next cycle src_valid=0 and all outputs 0; the next complete frame is received with sop and eop intact.
REQ-039 ready toggling 1/0 every cycle on a 4x2 frame -> 8 beats, no loss or duplication, src_data stable while stalled.
